// File: rtl/hs_merge_pkg.sv
// hs_merge_pkg: opcode classes, slot/state encodings and slot legality check for hs_merge_arbiter
package hs_merge_pkg;
  localparam int N_SLOT = 3;
  localparam logic [6:0] R    = 7'b0110011;
  localparam logic [6:0] I_OP = 7'b0010011;
  localparam logic [6:0] I_LD = 7'b0000011;
  localparam logic [6:0] U    = 7'b0110111;
  localparam logic [6:0] B    = 7'b1100011;
  localparam logic [6:0] J    = 7'b1101111;
  localparam logic [6:0] S    = 7'b0100011;
  localparam logic [6:0] NOP  = 7'b0000000;
  typedef enum logic [1:0] {SLOT_BJ = 2'd0, SLOT_ST = 2'd1, SLOT_ALU = 2'd2} slot_e;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACK = 2'd2, DROP = 2'd3} state_e;
  function automatic logic slot_legal(input logic [1:0] slot, input logic [6:0] op);
    return slot == SLOT_BJ  ? (op == B || op == J) :
           slot == SLOT_ST  ? (op == S) :
           slot == SLOT_ALU ? (op inside {R, I_OP, I_LD, U, NOP}) : 1'b0;
  endfunction
endpackage

// File: rtl/hs_merge_arbiter_if.sv
// hs_merge_arbiter_if: upstream request bundle and downstream req/ack channel of the merger
interface hs_merge_arbiter_if #(parameter int DATA_W = 32);
  logic [2:0]          req_i;
  logic [20:0]         opcode_i;
  logic [3*DATA_W-1:0] data_i;
  logic                ack_in;
  logic                req_out;
  logic [6:0]          opcode_o;
  logic [DATA_W-1:0]   data_o;
  logic [2:0]          ack_o;
  logic [1:0]          grant_o;
  logic                busy_o;
  logic                err_o;
  modport master (output req_i, opcode_i, data_i, ack_in,
                  input  req_out, opcode_o, data_o, ack_o, grant_o, busy_o, err_o);
  modport slave  (input  req_i, opcode_i, data_i, ack_in,
                  output req_out, opcode_o, data_o, ack_o, grant_o, busy_o, err_o);
endinterface

// File: rtl/hs_merge_pick.sv
// hs_merge_pick: picks the first pending slot, searching from ptr when rr is set, else from slot 0
module hs_merge_pick (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  input  logic       rr,
  output logic       valid,
  output logic [1:0] idx
);
  logic [1:0] k;
  always_comb begin
    valid = |req;
    idx = '0;
    k = '0;
    for (int i = 2; i >= 0; i--) begin
      k = 2'(rr ? (int'(ptr) + i) % 3 : i);
      if (req[k]) idx = k;
    end
  end
endmodule

// File: rtl/hs_merge_arbiter.sv
// hs_merge_arbiter: 3-way four-phase request merger onto one req/ack channel; define RR_ARB_EN for round-robin arbitration
module hs_merge_arbiter
  import hs_merge_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  hs_merge_arbiter_if.slave  bus
);
  state_e     state, state_nx;
  logic [2:0] cand, ack_nx;
  logic [1:0] ptr, pick_idx, gnt_nx, g;
  logic [6:0] pick_op;
  logic       pick_v, legal, grab, req_nx, err_nx;
`ifdef RR_ARB_EN
  localparam logic RR = 1'b1;
  logic [1:0] rr_ptr;
  assign ptr = rr_ptr;
  always_ff @(posedge clk)
    if (!rst_n) rr_ptr <= '0;
    else if (grab) rr_ptr <= pick_idx == 2'd2 ? 2'd0 : pick_idx + 2'd1;
`else
  localparam logic RR = 1'b0;
  assign ptr = '0;
`endif
  assign g       = bus.grant_o;
  assign cand    = bus.req_i & ~bus.ack_o;
  assign pick_op = bus.opcode_i[7*pick_idx +: 7];
  assign legal   = slot_legal(pick_idx, pick_op);
  assign grab    = state == IDLE && pick_v && !bus.ack_in;
  hs_merge_pick u_pick (.req(cand), .ptr(ptr), .rr(RR), .valid(pick_v), .idx(pick_idx));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grab) state_nx = legal ? REQ : DROP;
      REQ:     if (bus.req_out && bus.ack_in) state_nx = ACK;
      ACK:     if (!bus.req_i[g] && !bus.ack_in) state_nx = IDLE;
      DROP:    if (!bus.req_i[g]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // req_out rises one edge after the grant and drops on the edge that sees ack_in
  always_comb begin
    req_nx = state == REQ && state_nx == REQ;
    gnt_nx = grab ? pick_idx : g;
    ack_nx = (state_nx == ACK || state_nx == DROP) ? 3'b001 << gnt_nx : 3'b000;
    err_nx = bus.err_o | (state_nx == DROP);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.req_out  <= 1'b0;
      bus.ack_o    <= '0;
      bus.grant_o  <= '0;
      bus.opcode_o <= '0;
      bus.data_o   <= '0;
      bus.busy_o   <= 1'b0;
      bus.err_o    <= 1'b0;
    end else begin
      state       <= state_nx;
      bus.req_out <= req_nx;
      bus.ack_o   <= ack_nx;
      bus.grant_o <= gnt_nx;
      bus.busy_o  <= state_nx != IDLE;
      bus.err_o   <= err_nx;
      if (grab) begin
        bus.opcode_o <= pick_op;
        bus.data_o   <= bus.data_i[DATA_W*pick_idx +: DATA_W];
      end
    end
  end
endmodule

// File: tb/tb_hs_merge_arbiter.sv
// tb_hs_merge_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_hs_merge_arbiter;
  localparam logic [6:0] OP_R = 7'b0110011, OP_IO = 7'b0010011, OP_LD = 7'b0000011,
                         OP_U = 7'b0110111, OP_B = 7'b1100011, OP_J = 7'b1101111,
                         OP_S = 7'b0100011, OP_NOP = 7'b0000000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  hs_merge_arbiter_if #(.DATA_W(32)) bus ();
  hs_merge_arbiter #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_i = '0; bus.opcode_i = '0; bus.data_i = '0; bus.ack_in = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic serve(output logic [1:0] g, output bit ok);
    int n = 0;
    while (!bus.req_out && n < 8) begin tick(); n++; end
    ok = bus.req_out;
    g = bus.grant_o;
    bus.ack_in = 1'b1;
    tick();
    bus.req_i[g] = 1'b0;
    bus.ack_in = 1'b0;
    tick();
  endtask

  function automatic bit legal_model(int s, logic [6:0] op);
    if (s == 0) return op == OP_B || op == OP_J;
    if (s == 1) return op == OP_S;
    return op == OP_R || op == OP_IO || op == OP_LD || op == OP_U || op == OP_NOP;
  endfunction

  function automatic int pick_model(logic [2:0] c, int ptr);
    for (int i = 0; i < 3; i++) if (c[(ptr + i) % 3]) return (ptr + i) % 3;
    return -1;
  endfunction

  function automatic logic [6:0] rand_op(int s);
    logic [6:0] alu [5] = '{OP_R, OP_IO, OP_LD, OP_U, OP_NOP};
    if ($urandom_range(0, 4) == 0) return 7'($urandom);
    if (s == 0) return $urandom_range(0, 1) ? OP_B : OP_J;
    if (s == 1) return OP_S;
    return alu[$urandom_range(0, 4)];
  endfunction

  task automatic test_reset();
    bus.req_i = '0; bus.opcode_i = '0; bus.data_i = '0; bus.ack_in = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({bus.req_out, bus.ack_o, bus.grant_o, bus.busy_o, bus.err_o} !== 8'd0 || bus.opcode_o !== 7'd0 || bus.data_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b ack=%b grant=%0d busy=%b err=%b op=%h data=%h required all zero",
               bus.req_out, bus.ack_o, bus.grant_o, bus.busy_o, bus.err_o, bus.opcode_o, bus.data_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bus.req_i = 3'b100; bus.opcode_i[20:14] = OP_R; bus.data_i[95:64] = 32'hDEADBEEF;
    tick();
    checks++;
    if (bus.req_out !== 1'b0 || bus.busy_o !== 1'b1) begin
      errors++; $display("FAIL basic_grant_edge got req=%b busy=%b required req=0 busy=1", bus.req_out, bus.busy_o);
    end
    tick();
    checks++;
    if (bus.req_out !== 1'b1 || bus.data_o !== 32'hDEADBEEF || bus.grant_o !== 2'd2 || bus.opcode_o !== OP_R) begin
      errors++; $display("FAIL basic_req got req=%b data=%h grant=%0d op=%b required 1 deadbeef 2 %b",
                         bus.req_out, bus.data_o, bus.grant_o, bus.opcode_o, OP_R);
    end
    bus.ack_in = 1'b1;
    tick();
    checks++;
    if (bus.ack_o !== 3'b100 || bus.req_out !== 1'b0) begin
      errors++; $display("FAIL basic_ack got ack=%b req=%b required 100 0", bus.ack_o, bus.req_out);
    end
    bus.req_i[2] = 1'b0; bus.ack_in = 1'b0;
    tick();
    checks++;
    if (bus.ack_o !== 3'b000 || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL basic_release got ack=%b busy=%b required 000 0", bus.ack_o, bus.busy_o);
    end
  endtask

  task automatic test_priority();
    logic [1:0] g;
    bit ok;
`ifdef RR_ARB_EN
    int exp_g [3] = '{1, 2, 0};
`else
    int exp_g [3] = '{0, 1, 2};
`endif
    do_reset();
    bus.req_i = 3'b001; bus.opcode_i = {OP_R, OP_S, OP_B};
    serve(g, ok);
    checks++;
    if (g !== 2'd0 || !ok) begin
      errors++; $display("FAIL prio_single got grant=%0d req_seen=%0d required 0 1", g, ok);
    end
    bus.req_i = 3'b111; bus.data_i = {32'h2222, 32'h1111, 32'h0000};
    for (int i = 0; i < 3; i++) begin
      serve(g, ok);
      checks++;
      if (g !== 2'(exp_g[i]) || !ok) begin
        errors++; $display("FAIL prio_order[%0d] got grant=%0d req_seen=%0d required %0d 1", i, g, ok, exp_g[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [1:0] g;
    bit ok;
    bus.req_i = 3'b010; bus.opcode_i[13:7] = OP_R;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.req_out !== 1'b0 || bus.ack_o !== 3'b010 || bus.err_o !== 1'b1) begin
        errors++; $display("FAIL illegal_drop[%0d] got req=%b ack=%b err=%b required 0 010 1", i, bus.req_out, bus.ack_o, bus.err_o);
      end
    end
    bus.req_i[1] = 1'b0;
    tick();
    checks++;
    if (bus.ack_o !== 3'b000 || bus.busy_o !== 1'b0 || bus.err_o !== 1'b1) begin
      errors++; $display("FAIL illegal_exit got ack=%b busy=%b err=%b required 000 0 1", bus.ack_o, bus.busy_o, bus.err_o);
    end
    bus.opcode_i[13:7] = OP_S; bus.req_i = 3'b010;
    serve(g, ok);
    checks++;
    if (g !== 2'd1 || !ok || bus.err_o !== 1'b1) begin
      errors++; $display("FAIL illegal_then_legal got grant=%0d req_seen=%0d err=%b required 1 1 1", g, ok, bus.err_o);
    end
  endtask

  task automatic test_ack_order();
    for (int r = 0; r < 2; r++) begin
      bus.req_i = 3'b001; bus.opcode_i[6:0] = OP_B;
      tick(); tick();
      bus.ack_in = 1'b1;
      tick();
      if (r == 0) bus.ack_in = 1'b0; else bus.req_i[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        checks++;
        if (bus.ack_o !== 3'b001 || bus.busy_o !== 1'b1) begin
          errors++; $display("FAIL ack_hold[%0d][%0d] got ack=%b busy=%b required 001 1", r, i, bus.ack_o, bus.busy_o);
        end
      end
      bus.req_i[0] = 1'b0; bus.ack_in = 1'b0;
      tick();
      checks++;
      if (bus.ack_o !== 3'b000 || bus.busy_o !== 1'b0) begin
        errors++; $display("FAIL ack_exit[%0d] got ack=%b busy=%b required 000 0", r, bus.ack_o, bus.busy_o);
      end
    end
  endtask

  task automatic test_mid_reset();
    bus.req_i = 3'b100; bus.opcode_i[20:14] = OP_LD; bus.data_i[95:64] = 32'h12345678;
    tick(); tick();
    checks++;
    if (bus.req_out !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got req=%b required 1", bus.req_out);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.req_out !== 1'b0 || bus.ack_o !== 3'b000 || bus.busy_o !== 1'b0 || bus.grant_o !== 2'd0 || bus.data_o !== 32'd0) begin
      errors++; $display("FAIL midrst_clear got req=%b ack=%b busy=%b grant=%0d data=%h required all zero",
                         bus.req_out, bus.ack_o, bus.busy_o, bus.grant_o, bus.data_o);
    end
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (bus.req_out !== 1'b1 || bus.grant_o !== 2'd2 || bus.data_o !== 32'h12345678) begin
      errors++; $display("FAIL midrst_rearb got req=%b grant=%0d data=%h required 1 2 12345678", bus.req_out, bus.grant_o, bus.data_o);
    end
    bus.ack_in = 1'b1; tick();
    bus.req_i = '0; bus.ack_in = 1'b0; tick();
  endtask

  task automatic test_ack_idle();
    bus.ack_in = 1'b1; bus.req_i = 3'b001; bus.opcode_i[6:0] = OP_J;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.busy_o !== 1'b0 || bus.req_out !== 1'b0) begin
        errors++; $display("FAIL ackidle_hold[%0d] got busy=%b req=%b required 0 0", i, bus.busy_o, bus.req_out);
      end
    end
    bus.ack_in = 1'b0;
    tick(); tick();
    checks++;
    if (bus.req_out !== 1'b1 || bus.grant_o !== 2'd0 || bus.opcode_o !== OP_J) begin
      errors++; $display("FAIL ackidle_go got req=%b grant=%0d op=%b required 1 0 %b", bus.req_out, bus.grant_o, bus.opcode_o, OP_J);
    end
    bus.ack_in = 1'b1; tick();
    bus.req_i = '0; bus.ack_in = 1'b0; tick();
  endtask

  task automatic test_random();
    int w = 0, m_ptr = 0;
    bit m_busy = 0, m_legal = 0, m_fired = 0, m_acked = 0;
    logic [2:0] e_ack = '0, c;
    logic [1:0] e_grant = '0;
    logic [6:0] e_op = '0;
    logic [31:0] e_data = '0;
    bit e_req = 0, e_err = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        if (bus.ack_o[k] && bus.req_i[k] && $urandom_range(0, 2) == 0) bus.req_i[k] = 1'b0;
        else if (!bus.req_i[k] && !bus.ack_o[k] && $urandom_range(0, 3) == 0) begin
          bus.req_i[k] = 1'b1;
          bus.opcode_i[7*k +: 7] = rand_op(k);
          bus.data_i[32*k +: 32] = $urandom;
        end
      end
      if (bus.req_out && !bus.ack_in && $urandom_range(0, 1) == 0) bus.ack_in = 1'b1;
      else if (!bus.req_out && bus.ack_in && $urandom_range(0, 1) == 0) bus.ack_in = 1'b0;
      c = bus.req_i & ~e_ack;
      if (!m_busy) begin
        if (c != 0 && !bus.ack_in) begin
          w = pick_model(c, m_ptr);
          m_busy = 1; m_fired = 0; m_acked = 0;
          m_legal = legal_model(w, bus.opcode_i[7*w +: 7]);
          e_grant = 2'(w); e_op = bus.opcode_i[7*w +: 7]; e_data = bus.data_i[32*w +: 32];
`ifdef RR_ARB_EN
          m_ptr = (w + 1) % 3;
`endif
        end
      end else if (!m_legal) begin
        if (!bus.req_i[w]) m_busy = 0;
      end else if (!m_fired) m_fired = 1;
      else if (!m_acked) begin
        if (bus.ack_in) m_acked = 1;
      end else if (!bus.req_i[w] && !bus.ack_in) m_busy = 0;
      e_req = m_busy && m_legal && m_fired && !m_acked;
      e_ack = (m_busy && (!m_legal || m_acked)) ? 3'b001 << w : 3'b000;
      if (m_busy && !m_legal) e_err = 1;
      tick();
      checks++;
      if (bus.req_out !== e_req || bus.ack_o !== e_ack || bus.busy_o !== m_busy || bus.err_o !== e_err) begin
        errors++; $display("FAIL rand_hs cyc=%0d got req=%b ack=%b busy=%b err=%b required %b %b %b %b",
                           cyc, bus.req_out, bus.ack_o, bus.busy_o, bus.err_o, e_req, e_ack, m_busy, e_err);
      end
      checks++;
      if (bus.grant_o !== e_grant || bus.opcode_o !== e_op || bus.data_o !== e_data) begin
        errors++; $display("FAIL rand_payload cyc=%0d got grant=%0d op=%b data=%h required %0d %b %h",
                           cyc, bus.grant_o, bus.opcode_o, bus.data_o, e_grant, e_op, e_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_illegal();
    test_ack_order();
    test_mid_reset();
    test_ack_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end
endmodule
